// File: rtl/bp_pkg.sv
// Shared types and constants for the agree-predictor update sequencer.
//   upd_entry_t    : one buffered commit-stage update as it sits in the FIFO
//   bp_state_e     : sequencer state (table sweep vs. normal drain)
//   PHT_WEAK_AGREE : counter value the PHT loads when pht_init_o is set
//   sw_width()     : sweep counter width, wide enough to cover the larger table
// The struct widths come from the package defaults; bp_update_ctrl takes its
// parameters from the same constants so the two always agree.
package bp_pkg;

  localparam int BP_INDEX_WIDTH   = 6;
  localparam int BP_HISTORY_WIDTH = 8;
  localparam int BP_TAG_WIDTH     = 30 - BP_INDEX_WIDTH;
  localparam int BP_FIFO_DEPTH    = 4;

  // Two-bit PHT counter encoding for "weakly agree".
  localparam logic [1:0] PHT_WEAK_AGREE = 2'b10;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic                        is_jmp;
    logic                        btb_hit;
    logic                        taken;
    logic                        bias;
    logic [BP_INDEX_WIDTH-1:0]   btb_index;
    logic [BP_HISTORY_WIDTH-1:0] pht_index;
    logic [BP_TAG_WIDTH-1:0]     tag;
    logic [31:0]                 target;
    logic [BP_HISTORY_WIDTH-1:0] ghr;
  } upd_entry_t;

  function automatic int sw_width(input int index_width, input int history_width);
    return (index_width > history_width) ? index_width : history_width;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// bp_upd_fifo: synchronous FIFO for buffered predictor updates.
//   clk_i            clock
//   clear_i          synchronous clear; empties the FIFO, wins over push/pop
//   push_i / wdata_i write a word (ignored when full unless popping too)
//   pop_i            advance the head (ignored when empty)
//   rdata_o          current head word, valid whenever empty_o is low
//   full_o / empty_o occupancy flags
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter. DEPTH must be a power of two, at least 2.
module bp_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same edge, so push is legal when full.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: owns every write-enable of the agree predictor (BTB, PHT,
// GHR). After reset or a flush request it sweeps all table entries to their
// invalid / weakly-agree state; otherwise it drains buffered commit updates
// at one table write per cycle.
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_req_i         one-cycle pulse: restart the sweep, drop queued updates
//   upd_*_i, upd_ready_o commit update channel
//   btb_*_o             BTB write port (btb_inv_o clears the valid bit)
//   pht_*_o             PHT write port (pht_init_o loads weakly-agree)
//   ghr_*_o             GHR shift / clear controls
//   busy_o              sweep in progress
//   flush_done_o        one-cycle pulse with the final sweep write
//   dbg_state_o         current sequencer state
//
// Update handshake: a transfer happens on a rising edge where upd_valid_i and
// upd_ready_o are both high. upd_ready_o depends only on FIFO fullness and
// flush_req_i, never on upd_valid_i. Non-jump updates complete the handshake
// but are not stored.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH   = BP_INDEX_WIDTH,
  parameter int HISTORY_WIDTH = BP_HISTORY_WIDTH,
  parameter int FIFO_DEPTH    = BP_FIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_req_i,
  input  logic                      upd_valid_i,
  output logic                      upd_ready_o,
  input  logic                      upd_is_jmp_i,
  input  logic                      upd_btb_hit_i,
  input  logic                      upd_taken_i,
  input  logic                      upd_bias_i,
  input  logic [INDEX_WIDTH-1:0]    upd_btb_index_i,
  input  logic [30-INDEX_WIDTH-1:0] upd_tag_i,
  input  logic [31:0]               upd_target_i,
  input  logic [HISTORY_WIDTH-1:0]  upd_pht_index_i,
  input  logic [HISTORY_WIDTH-1:0]  upd_ghr_i,
  output logic                      btb_wren_o,
  output logic                      btb_inv_o,
  output logic [INDEX_WIDTH-1:0]    btb_wr_index_o,
  output logic [30-INDEX_WIDTH-1:0] btb_wr_tag_o,
  output logic [31:0]               btb_wr_target_o,
  output logic                      btb_wr_bias_o,
  output logic                      pht_wren_o,
  output logic                      pht_init_o,
  output logic [HISTORY_WIDTH-1:0]  pht_wr_index_o,
  output logic                      pht_wr_agree_o,
  output logic                      ghr_update_en_o,
  output logic                      ghr_taken_o,
  output logic                      ghr_clear_o,
  output logic                      busy_o,
  output logic                      flush_done_o,
  output bp_state_e                 dbg_state_o
);

  localparam int SW = sw_width(INDEX_WIDTH, HISTORY_WIDTH);

  bp_state_e        state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             clear_pend_q, clear_pend_d;
  logic             sweep_last;

  upd_entry_t       in_entry;
  upd_entry_t       head;
  logic [$bits(upd_entry_t)-1:0] fifo_rdata;
  logic             fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;

  assign in_entry = '{is_jmp:    upd_is_jmp_i,
                      btb_hit:   upd_btb_hit_i,
                      taken:     upd_taken_i,
                      bias:      upd_bias_i,
                      btb_index: upd_btb_index_i,
                      pht_index: upd_pht_index_i,
                      tag:       upd_tag_i,
                      target:    upd_target_i,
                      ghr:       upd_ghr_i};
  assign head = upd_entry_t'(fifo_rdata);

  assign fifo_push  = upd_valid_i && upd_ready_o && upd_is_jmp_i;
  assign fifo_clear = rst_i || flush_req_i;
  assign sweep_last = (state_q == ST_SWEEP) && (cnt_q == '1);
  assign dbg_state_o = state_q;

  bp_upd_fifo #(
    .WIDTH ($bits(upd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .wdata_i (in_entry),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_SWEEP;
      cnt_q        <= '0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  // Next state. The counter wraps to 0 on the last sweep count, which is
  // exactly the value the next sweep needs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_pend_d = 1'b0;
    if (flush_req_i) begin
      state_d      = ST_SWEEP;
      cnt_d        = '0;
      clear_pend_d = 1'b1;
    end else if (state_q == ST_SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (sweep_last) state_d = ST_RUN;
    end
  end

  // Outputs. Sweep and drain are mutually exclusive by state, so each table
  // sees at most one write per cycle. A flush only affects the next cycle,
  // which lets the pop already under way in the flush cycle finish.
  always_comb begin
    upd_ready_o     = 1'b0;
    btb_wren_o      = 1'b0;
    btb_inv_o       = 1'b0;
    btb_wr_index_o  = '0;
    btb_wr_tag_o    = '0;
    btb_wr_target_o = '0;
    btb_wr_bias_o   = 1'b0;
    pht_wren_o      = 1'b0;
    pht_init_o      = 1'b0;
    pht_wr_index_o  = '0;
    pht_wr_agree_o  = 1'b0;
    ghr_update_en_o = 1'b0;
    ghr_taken_o     = 1'b0;
    ghr_clear_o     = 1'b0;
    busy_o          = 1'b0;
    flush_done_o    = 1'b0;
    fifo_pop        = 1'b0;
    if (rst_i) begin
      ghr_clear_o = 1'b1;
    end else begin
      upd_ready_o = !fifo_full && !flush_req_i;
      ghr_clear_o = clear_pend_q;
      if (state_q == ST_SWEEP) begin
        busy_o = 1'b1;
        // Counter bits above a table's index width being zero means the
        // count is still inside that table.
        if ((cnt_q >> INDEX_WIDTH) == '0) begin
          btb_wren_o     = 1'b1;
          btb_inv_o      = 1'b1;
          btb_wr_index_o = cnt_q[INDEX_WIDTH-1:0];
        end
        if ((cnt_q >> HISTORY_WIDTH) == '0) begin
          pht_wren_o     = 1'b1;
          pht_init_o     = 1'b1;
          pht_wr_index_o = cnt_q[HISTORY_WIDTH-1:0];
        end
        // A flush on the last count restarts the sweep instead of ending it.
        flush_done_o = sweep_last && !flush_req_i;
      end else if (!fifo_empty && head.is_jmp) begin
        fifo_pop        = 1'b1;
        btb_wren_o      = !head.btb_hit;
        btb_wr_index_o  = head.btb_index;
        btb_wr_tag_o    = head.tag;
        btb_wr_target_o = head.target;
        btb_wr_bias_o   = head.taken;
        pht_wren_o      = 1'b1;
        pht_wr_index_o  = head.pht_index ^ head.ghr;
        pht_wr_agree_o  = !(head.taken ^ head.bias);
        ghr_update_en_o = 1'b1;
        ghr_taken_o     = head.taken;
      end
    end
  end

endmodule
